// File: rtl/demux_pkg.sv
// Shared constants for the demux/mux steering family.
//   SEL_A..SEL_D : 2-bit select encodings for outputs a..d
//   N_OUT        : number of steered outputs
//   SEL_W        : select width
package demux_pkg;

    localparam int unsigned N_OUT = 4;
    localparam int unsigned SEL_W = 2;

    localparam logic [SEL_W-1:0] SEL_A = 2'b00;
    localparam logic [SEL_W-1:0] SEL_B = 2'b01;
    localparam logic [SEL_W-1:0] SEL_C = 2'b10;
    localparam logic [SEL_W-1:0] SEL_D = 2'b11;

endpackage

// File: rtl/demux_1to4_decode_2to4.sv
// Combinational 2-bit to one-hot decoder, all-zero on any unmatched select.
//   sel : binary select, MSB first
//   en  : one-hot enable, en[i] set when sel == i
module decode_2to4
    import demux_pkg::*;
(
    input  logic [SEL_W-1:0] sel,
    output logic [N_OUT-1:0] en
);

    // Unmatched (X/Z) selects fall to the default, so no output is enabled.
    always_comb begin
        en = '0;
        case (sel)
            SEL_A:   en = 4'b0001;
            SEL_B:   en = 4'b0010;
            SEL_C:   en = 4'b0100;
            SEL_D:   en = 4'b1000;
            default: en = '0;
        endcase
    end

endmodule

// File: rtl/demux_1to4.sv
// 1-to-4 demultiplexer: steers y onto a/b/c/d by {S_1,S_0}; unselected
// outputs are zero.
//   clk, rst   : clock (rising edge) and async active-high reset
//   y          : data to steer (WIDTH bits)
//   S_1, S_0   : select MSB / LSB
//   a, b, c, d : outputs for select 00 / 01 / 10 / 11
//   REG_OUT    : 1 = registered outputs (1-cycle latency), 0 = combinational
module demux_1to4
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH   = 1,
    parameter int unsigned REG_OUT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] y,
    input  logic             S_0,
    input  logic             S_1,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d
);

    logic [N_OUT-1:0] en;
    logic [WIDTH-1:0] gated [N_OUT];

    decode_2to4 u_decode (
        .sel ({S_1, S_0}),
        .en  (en)
    );

    // Per-output AND gating with the replicated enable bit.
    always_comb begin
        for (int i = 0; i < int'(N_OUT); i++) begin
            gated[i] = y & {WIDTH{en[i]}};
        end
    end

    generate
        if (REG_OUT != 0) begin : g_reg
            // Output register bank; reset clears immediately and drops any pending value.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a <= '0;
                    b <= '0;
                    c <= '0;
                    d <= '0;
                end else begin
                    a <= gated[0];
                    b <= gated[1];
                    c <= gated[2];
                    d <= gated[3];
                end
            end
        end else begin : g_bypass
            // Clock and reset have no function in the bypass build.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;

            assign a = gated[0];
            assign b = gated[1];
            assign c = gated[2];
            assign d = gated[3];
        end
    endgenerate

endmodule

// File: tb/tb_demux_1to4.sv
// Directed self-checking bench for demux_1to4: registered WIDTH=1 instance
// and combinational WIDTH=8 instance.
module tb_demux_1to4;

    logic       clk;
    logic       rst;

    // Registered, WIDTH=1 instance
    logic [0:0] y1;
    logic       s0_1, s1_1;
    logic [0:0] a1, b1, c1, d1;

    // Combinational, WIDTH=8 instance
    logic [7:0] y8;
    logic       s0_8, s1_8;
    logic [7:0] a8, b8, c8, d8;

    int compared   = 0;
    int mismatched = 0;

    demux_1to4 #(.WIDTH(1), .REG_OUT(1)) u_dut_reg (
        .clk (clk), .rst (rst), .y (y1), .S_0 (s0_1), .S_1 (s1_1),
        .a (a1), .b (b1), .c (c1), .d (d1)
    );

    demux_1to4 #(.WIDTH(8), .REG_OUT(0)) u_dut_comb (
        .clk (clk), .rst (rst), .y (y8), .S_0 (s0_8), .S_1 (s1_8),
        .a (a8), .b (b8), .c (c8), .d (d8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Check all four registered outputs against a 4-bit {a,b,c,d} pattern.
    task automatic check_reg(input string tag, input logic [3:0] abcd);
        check({tag, ".a"}, 8'(a1), 8'(abcd[3]));
        check({tag, ".b"}, 8'(b1), 8'(abcd[2]));
        check({tag, ".c"}, 8'(c1), 8'(abcd[1]));
        check({tag, ".d"}, 8'(d1), 8'(abcd[0]));
    endtask

    task automatic check_comb(input string tag, input logic [7:0] ea, input logic [7:0] eb,
                              input logic [7:0] ec, input logic [7:0] ed);
        check({tag, ".a"}, a8, ea);
        check({tag, ".b"}, b8, eb);
        check({tag, ".c"}, c8, ec);
        check({tag, ".d"}, d8, ed);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; y1 = 1'b1; s1_1 = 1'b1; s0_1 = 1'b1;
        y8 = 8'h00; s1_8 = 1'b0; s0_8 = 1'b0;

        // Reset held with y=1, sel=11: outputs stay zero across edges.
        #1;
        check_reg("rst_hold0", 4'b0000);
        tick;
        check_reg("rst_hold1", 4'b0000);
        tick;
        check_reg("rst_hold2", 4'b0000);

        // Release between edges; d updates at the next edge.
        rst = 1'b0;
        #2;
        check_reg("rst_rel_pre", 4'b0000);
        tick;
        check_reg("rst_rel_d", 4'b0001);

        // Sweep sel with y=1.
        s1_1 = 1'b0; s0_1 = 1'b0; tick; check_reg("sweep00", 4'b1000);
        s1_1 = 1'b0; s0_1 = 1'b1; tick; check_reg("sweep01", 4'b0100);
        s1_1 = 1'b1; s0_1 = 1'b0; tick; check_reg("sweep10", 4'b0010);
        s1_1 = 1'b1; s0_1 = 1'b1; tick; check_reg("sweep11", 4'b0001);

        // Latency: changing inputs does not move outputs before the edge.
        s1_1 = 1'b0; s0_1 = 1'b0;
        #3;
        check_reg("latency_hold", 4'b0001);
        tick;
        check_reg("latency_upd", 4'b1000);

        // Zero data on every select.
        y1 = 1'b0;
        s1_1 = 1'b0; s0_1 = 1'b0; tick; check_reg("zero00", 4'b0000);
        s1_1 = 1'b0; s0_1 = 1'b1; tick; check_reg("zero01", 4'b0000);
        s1_1 = 1'b1; s0_1 = 1'b0; tick; check_reg("zero10", 4'b0000);
        s1_1 = 1'b1; s0_1 = 1'b1; tick; check_reg("zero11", 4'b0000);

        // Same-cycle change of select and data: no b residue.
        y1 = 1'b1; s1_1 = 1'b0; s0_1 = 1'b1; tick; check_reg("same_pre", 4'b0100);
        y1 = 1'b0; s1_1 = 1'b1; s0_1 = 1'b0; tick; check_reg("same_post", 4'b0000);

        // Mid-run reset clears c asynchronously before the next edge.
        y1 = 1'b1; s1_1 = 1'b1; s0_1 = 1'b0; tick; check_reg("mid_pre", 4'b0010);
        #2;
        rst = 1'b1;
        #1;
        check_reg("mid_async", 4'b0000);
        tick;
        check_reg("mid_held", 4'b0000);
        #2;
        rst = 1'b0;
        #1;
        check_reg("mid_rel_pre", 4'b0000);
        tick;
        check_reg("mid_rel_c", 4'b0010);

        // Combinational WIDTH=8 instance, zero-cycle path.
        y8 = 8'hA5; s1_8 = 1'b0; s0_8 = 1'b1;
        #1;
        check_comb("comb01", 8'h00, 8'hA5, 8'h00, 8'h00);
        y8 = 8'h3C; s1_8 = 1'b1; s0_8 = 1'b1;
        #1;
        check_comb("comb11", 8'h00, 8'h00, 8'h00, 8'h3C);
        y8 = 8'h81; s1_8 = 1'b0; s0_8 = 1'b0;
        #1;
        check_comb("comb00", 8'h81, 8'h00, 8'h00, 8'h00);
        y8 = 8'h00; s1_8 = 1'b1; s0_8 = 1'b0;
        #1;
        check_comb("comb_zero", 8'h00, 8'h00, 8'h00, 8'h00);

        // Reset has no effect on the combinational build.
        y8 = 8'h5A; s1_8 = 1'b1; s0_8 = 1'b0; rst = 1'b1;
        #1;
        check_comb("comb_rst", 8'h00, 8'h00, 8'h5A, 8'h00);
        rst = 1'b0;

        // Unknown select LSB: all zero; a two-state simulator resolves it to a known value.
        y8 = 8'hFF; s1_8 = 1'b0; s0_8 = 1'bx;
        #1;
        if ($isunknown(s0_8)) begin
            check_comb("comb_x", 8'h00, 8'h00, 8'h00, 8'h00);
        end else begin
            check_comb("comb_x2s", s0_8 ? 8'h00 : 8'hFF, s0_8 ? 8'hFF : 8'h00, 8'h00, 8'h00);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
